// File: rtl/uart_word_packer_pkg.sv
// uart_word_packer_pkg: shared FSM state encoding and default timeout for the UART word packer.
//   Exports: state_t (WAIT_HI / WAIT_LO), DEF_TIMEOUT_CYC.
package uart_word_packer_pkg;
    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;
    localparam int DEF_TIMEOUT_CYC = 2000;
endpackage

// File: rtl/uart_word_packer_if.sv
// uart_word_packer_if: byte input, word stream and status signals of the UART word packer.
//   rx_byte/rx_done      byte strobe from the UART receiver
//   word_data/valid/ready  FWFT word stream towards the consumer
//   fifo_count/overflow/timeout_err/clr_err  status and error control
//   master = packer side, slave = byte source / word consumer side.
interface uart_word_packer_if #(parameter int DEPTH = 8);
    logic [7:0]              rx_byte;
    logic                    rx_done;
    logic [15:0]             word_data;
    logic                    word_valid;
    logic                    word_ready;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;
    logic                    timeout_err;
    logic                    clr_err;
    modport master (
        input  rx_byte, rx_done, word_ready, clr_err,
        output word_data, word_valid, fifo_count, overflow, timeout_err
    );
    modport slave (
        output rx_byte, rx_done, word_ready, clr_err,
        input  word_data, word_valid, fifo_count, overflow, timeout_err
    );
endinterface

// File: rtl/uart_word_packer_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count.
//   clk, rst_n    clock, async active-low reset
//   push/push_data  write request; accepted when not full or when a pop happens in the same cycle
//   pop           advance head; ignored when empty
//   pop_data      head word (0 while empty)
//   full, empty, count  occupancy status
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty    = count == '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer: pairs received UART bytes MSB-first into 16-bit words and buffers them in a FWFT FIFO.
//   clk, rst_n  clock, async active-low reset
//   bus         uart_word_packer_if.master: rx_byte/rx_done in, word_data/word_valid/word_ready stream out,
//               fifo_count, sticky overflow (cleared by clr_err), timeout_err pulse on orphan high byte drop.
module uart_word_packer
    import uart_word_packer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TMR_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_word_packer_if.master    bus
);
    state_t              state;
    logic [7:0]          hi_reg;
    logic [TMR_W-1:0]    timer;
    logic                overflow, timeout_err;
    logic                push, full, empty;

    // A low byte completes a word; if the FIFO is full with no pop the word is lost but pairing stays aligned.
    assign push            = state == WAIT_LO && bus.rx_done;
    assign bus.word_valid  = !empty;
    assign bus.overflow    = overflow;
    assign bus.timeout_err = timeout_err;

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({hi_reg, bus.rx_byte}),
        .pop       (bus.word_ready),
        .pop_data  (bus.word_data),
        .full      (full),
        .empty     (empty),
        .count     (bus.fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_HI;
            hi_reg      <= '0;
            timer       <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            // full implies non-empty, so word_ready alone means a pop frees a slot this cycle
            overflow    <= (push && full && !bus.word_ready) ? 1'b1 : bus.clr_err ? 1'b0 : overflow;
            if (state == WAIT_HI) begin
                if (bus.rx_done) begin
                    hi_reg <= bus.rx_byte;
                    timer  <= '0;
                    state  <= WAIT_LO;
                end
            end else if (bus.rx_done) begin
                timer <= '0;
                state <= WAIT_HI;
            end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                timeout_err <= 1'b1;
                timer       <= '0;
                state       <= WAIT_HI;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: self-checking bench for uart_word_packer (vector table, directed corner cases, random vs. model).
module tb_uart_word_packer;
    localparam int DEPTH = 8;
    localparam int TO    = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_word_packer_if #(.DEPTH(DEPTH)) bus();

    uart_word_packer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO), .TMR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: queue of stored words, optional pending high byte with idle-cycle age.
    logic [15:0] mq[$];
    logic        pend;
    logic [7:0]  mhi;
    int          idle;
    logic        movf;
    logic        mto;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(bus.word_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("data", 32'(bus.word_data), 32'(mq[0]));
        chk("count", 32'(bus.fifo_count), 32'(mq.size()));
        chk("overflow", 32'(bus.overflow), 32'(movf));
        chk("timeout_err", 32'(bus.timeout_err), 32'(mto));
    endtask

    task automatic cyc(input logic [7:0] b, input logic d, input logic r, input logic c);
        logic drop;
        drop = 1'b0;
        bus.rx_byte = b;
        bus.rx_done = d;
        bus.word_ready = r;
        bus.clr_err = c;
        mto = 1'b0;
        if (r && mq.size() > 0) void'(mq.pop_front());
        if (d) begin
            if (pend) begin
                if (mq.size() < DEPTH) mq.push_back({mhi, b});
                else drop = 1'b1;
                pend = 1'b0;
            end else begin
                pend = 1'b1;
                mhi = b;
                idle = 0;
            end
        end else if (pend) begin
            idle++;
            if (idle == TO) begin
                pend = 1'b0;
                mto = 1'b1;
            end
        end
        movf = drop ? 1'b1 : c ? 1'b0 : movf;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        bus.rx_done = 1'b0;
        bus.word_ready = 1'b0;
        bus.clr_err = 1'b0;
        bus.rx_byte = 8'h00;
        rst_n = 1'b0;
        mq.delete();
        pend = 1'b0;
        idle = 0;
        movf = 1'b0;
        mto = 1'b0;
        #2;
        check_model();
        chk("rst_data", 32'(bus.word_data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int dens;
        tbl[0] = '{8'hAB, 8'hCD, 16'hABCD};
        tbl[1] = '{8'h00, 8'hFF, 16'h00FF};
        tbl[2] = '{8'hFF, 8'h00, 16'hFF00};
        tbl[3] = '{8'h5A, 8'hA5, 16'h5AA5};
        tbl[4] = '{8'h80, 8'h01, 16'h8001};

        do_reset();
        cyc(8'h00, 1'b0, 1'b0, 1'b0);

        // byte pairs with consumer ready: word appears the cycle after the low byte
        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].hi, 1'b1, 1'b1, 1'b0);
            chk("tbl_valid_after_hi", 32'(bus.word_valid), 32'h0);
            cyc(tbl[i].lo, 1'b1, 1'b1, 1'b0);
            chk("tbl_valid", 32'(bus.word_valid), 32'h1);
            chk("tbl_data", 32'(bus.word_data), 32'(tbl[i].exp));
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
            chk("tbl_popped", 32'(bus.word_valid), 32'h0);
        end

        // orphan high byte times out, following pair is aligned
        cyc(8'h12, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("to_not_yet", 32'(bus.timeout_err), 32'h0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("to_pulse", 32'(bus.timeout_err), 32'h1);
        cyc(8'h34, 1'b1, 1'b0, 1'b0);
        chk("to_single_pulse", 32'(bus.timeout_err), 32'h0);
        chk("to_no_word", 32'(bus.word_valid), 32'h0);
        cyc(8'h56, 1'b1, 1'b0, 1'b0);
        chk("to_word", 32'(bus.word_data), 32'h3456);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);

        // low byte lands on the exact timeout cycle: byte wins
        cyc(8'h12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h34, 1'b1, 1'b0, 1'b0);
        chk("edge_word", 32'(bus.word_data), 32'h1234);
        chk("edge_no_to", 32'(bus.timeout_err), 32'h0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("edge_no_to_late", 32'(bus.timeout_err), 32'h0);

        // overflow with consumer stalled
        for (int i = 0; i < 2 * (DEPTH + 1); i++) cyc(8'(i + 16), 1'b1, 1'b0, 1'b0);
        chk("ovf_count", 32'(bus.fifo_count), 32'(DEPTH));
        chk("ovf_flag", 32'(bus.overflow), 32'h1);
        chk("ovf_head", 32'(bus.word_data), 32'h1011);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'h0);

        // full FIFO, pop in the same cycle as a completed word
        cyc(8'hA0, 1'b1, 1'b0, 1'b0);
        cyc(8'hA1, 1'b1, 1'b1, 1'b0);
        chk("full_pp_count", 32'(bus.fifo_count), 32'(DEPTH));
        chk("full_pp_ovf", 32'(bus.overflow), 32'h0);
        for (int k = 1; k < DEPTH; k++) begin
            chk("drain_order", 32'(bus.word_data), 32'({8'(16 + 2 * k), 8'(17 + 2 * k)}));
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_last", 32'(bus.word_data), 32'hA0A1);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(bus.word_valid), 32'h0);

        // reset mid-word with words queued
        cyc(8'h11, 1'b1, 1'b0, 1'b0);
        cyc(8'h22, 1'b1, 1'b0, 1'b0);
        cyc(8'h33, 1'b1, 1'b0, 1'b0);
        cyc(8'h44, 1'b1, 1'b0, 1'b0);
        cyc(8'hEE, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'h2);
        do_reset();
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_count", 32'(bus.fifo_count), 32'h0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        cyc(8'h02, 1'b1, 1'b0, 1'b0);
        chk("rst_word", 32'(bus.word_data), 32'h0102);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);

        // random traffic in blocks of varying byte density
        for (int blk = 0; blk < 20; blk++) begin
            dens = $urandom_range(0, 3);
            dens = (dens == 0) ? 0 : (dens == 1) ? 1 : (dens == 2) ? 4 : 8;
            for (int i = 0; i < 150; i++)
                cyc(8'($urandom), 1'($urandom_range(0, 9) < dens), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
